// File: rtl/serial_link_sched.sv
// -----------------------------------------------------------------------------
// serial_link_sched
//   Arbitrates the shared two-wire serial link between two requesters:
//   UP (S1->S2) and DN (S2->S1). A grant holds the endpoints in reset for GAP
//   cycles (SETUP), then releases them (RUN) until both endpoints report done
//   or the RUN timer expires. A one-cycle DONE state pulses the ack for the
//   granted side, with err flagging a timeout.
//
//   Optional feature: define SCHED_RETRY_EN to retry a timed-out grant once
//   (back to SETUP, same side) before reporting err.
//
// Parameters
//   GAP      cycles ep_rst is held high in SETUP (>=1)
//   TIMEOUT  RUN cycles before a transfer is aborted (>=2)
//   TO_W     RUN timer width, must hold TIMEOUT
//   CNT_W    width of the successful-transfer counter
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active low
//   req_up    in   level request for an S1->S2 transfer, held until ack_up
//   req_dn    in   level request for an S2->S1 transfer, held until ack_dn
//   ack_up    out  1-cycle pulse, UP transfer finished (see err)
//   ack_dn    out  1-cycle pulse, DN transfer finished (see err)
//   err       out  1-cycle pulse with ack_*, transfer timed out
//   ep_rst    out  endpoint reset, 1 = endpoints idle
//   updown    out  link direction, 1 = UP, 0 = DN
//   s1_done   in   completion flag from endpoint S1
//   s2_done   in   completion flag from endpoint S2
//   busy      out  1 while a transfer is in SETUP/RUN/DONE
//   xfer_cnt  out  successful transfers since reset, wraps
// -----------------------------------------------------------------------------
module serial_link_sched #(
  parameter int GAP     = 2,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_up,
  input  logic             req_dn,
  output logic             ack_up,
  output logic             ack_dn,
  output logic             err,
  output logic             ep_rst,
  output logic             updown,
  input  logic             s1_done,
  input  logic             s2_done,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TO_W-1:0]    timer_q, timer_d;
  logic               lat1_q, lat1_d;
  logic               lat2_q, lat2_d;
  logic               rr_q, rr_d;        // 1 = UP wins the next contended grant
  logic               ep_rst_q, ep_rst_d;
  logic               updown_q, updown_d;
  logic               ack_up_q, ack_up_d;
  logic               ack_dn_q, ack_dn_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef SCHED_RETRY_EN
  logic               retry_q, retry_d;
`endif

  logic grant_up;
  logic l1, l2;
  logic timed_out;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    timer_d   = timer_q;
    lat1_d    = lat1_q;
    lat2_d    = lat2_q;
    rr_d      = rr_q;
    updown_d  = updown_q;
    cnt_d     = cnt_q;
    ack_up_d  = 1'b0;
    ack_dn_d  = 1'b0;
    err_d     = 1'b0;
    grant_up  = 1'b0;
    timed_out = 1'b0;
    // Same-cycle arrival counts: the live input is OR'ed with the sticky latch.
    l1        = lat1_q | s1_done;
    l2        = lat2_q | s2_done;
`ifdef SCHED_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef SCHED_RETRY_EN
        retry_d = 1'b0;
`endif
        if (req_up || req_dn) begin
          grant_up = req_up && (!req_dn || rr_q);
          updown_d = grant_up;
          rr_d     = !grant_up;
          gap_d    = '0;
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        lat1_d = 1'b0;
        lat2_d = 1'b0;
        if (gap_q == GAP_W'(GAP - 1)) begin
          timer_d = '0;
          state_d = S_RUN;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      S_RUN: begin
        lat1_d = l1;
        lat2_d = l2;
        // Completion is tested first so it wins over a coincident timeout.
        if (l1 && l2) begin
          state_d = S_DONE;
        end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
`ifdef SCHED_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            gap_d   = '0;
            state_d = S_SETUP;
          end else begin
            timed_out = 1'b1;
            state_d   = S_DONE;
          end
`else
          timed_out = 1'b1;
          state_d   = S_DONE;
`endif
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    ep_rst_d = (state_d != S_RUN);
    busy_d   = (state_d != S_IDLE);
    if (state_d == S_DONE && state_q == S_RUN) begin
      ack_up_d = updown_q;
      ack_dn_d = !updown_q;
      err_d    = timed_out;
      if (!timed_out) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      timer_q  <= '0;
      lat1_q   <= 1'b0;
      lat2_q   <= 1'b0;
      rr_q     <= 1'b1;
      ep_rst_q <= 1'b1;
      updown_q <= 1'b0;
      ack_up_q <= 1'b0;
      ack_dn_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SCHED_RETRY_EN
      retry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      timer_q  <= timer_d;
      lat1_q   <= lat1_d;
      lat2_q   <= lat2_d;
      rr_q     <= rr_d;
      ep_rst_q <= ep_rst_d;
      updown_q <= updown_d;
      ack_up_q <= ack_up_d;
      ack_dn_q <= ack_dn_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
`ifdef SCHED_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  assign ack_up   = ack_up_q;
  assign ack_dn   = ack_dn_q;
  assign err      = err_q;
  assign ep_rst   = ep_rst_q;
  assign updown   = updown_q;
  assign busy     = busy_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_serial_link_sched.sv
// Testbench for serial_link_sched (GAP=2, TIMEOUT=16, CNT_W=2).
module tb_serial_link_sched;

  localparam int GAP     = 2;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 5;
  localparam int CNT_W   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_up = 1'b0;
  logic             req_dn = 1'b0;
  logic             s1_done = 1'b0;
  logic             s2_done = 1'b0;
  logic             ack_up, ack_dn, err, ep_rst, updown, busy;
  logic [CNT_W-1:0] xfer_cnt;

  serial_link_sched #(.GAP(GAP), .TIMEOUT(TIMEOUT), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_up(req_up), .req_dn(req_dn),
    .ack_up(ack_up), .ack_dn(ack_dn), .err(err), .ep_rst(ep_rst),
    .updown(updown), .s1_done(s1_done), .s2_done(s2_done),
    .busy(busy), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit up;
    bit err;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cnt_m = 0;

  task automatic chk(input string name, input int act, input int want);
    total = total + 1;
    if (act != want) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && (ack_up || ack_dn || err)) begin
      total = total + 1;
      if (q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_ack: ack_up=%0b ack_dn=%0b err=%0b at cycle %0d",
                 ack_up, ack_dn, err, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (cyc != e.cyc || ack_up != e.up || ack_dn != !e.up || err != e.err ||
            int'(xfer_cnt) != e.cnt || updown != e.up) begin
          bad = bad + 1;
          $display("FAIL ack: got cyc=%0d up=%0b dn=%0b err=%0b cnt=%0d updown=%0b want cyc=%0d up=%0b err=%0b cnt=%0d",
                   cyc, ack_up, ack_dn, err, xfer_cnt, updown, e.cyc, e.up, e.err, e.cnt);
        end
      end
    end
  end

  // One transfer from IDLE. k1/k2: RUN-cycle index of the s1/s2 done pulse,
  // -1 = never (timeout).
  task automatic xfer(input bit up, input int k1, input int k2, input bit drop_early);
    int   run0;
    int   kd;
    int   ackc;
    bit   e_err;
    exp_t e;
    if (up) req_up = 1'b1; else req_dn = 1'b1;
    chk("idle_ep_rst", ep_rst, 1);
    tick();
    chk("setup_ep_rst", ep_rst, 1);
    chk("setup_updown", updown, up);
    tick();
    tick();
    run0 = cyc;
    chk("run_ep_rst", ep_rst, 0);
    chk("run_busy", busy, 1);
    if (drop_early) begin
      req_up = 1'b0;
      req_dn = 1'b0;
    end
    e_err = (k1 < 0 || k2 < 0);
    if (!e_err) begin
      kd    = (k1 > k2) ? k1 : k2;
      ackc  = run0 + kd + 1;
      cnt_m = (cnt_m + 1) % 4;
    end else begin
`ifdef SCHED_RETRY_EN
      ackc = run0 + TIMEOUT + GAP + TIMEOUT;
`else
      ackc = run0 + TIMEOUT;
`endif
    end
    e.cyc = ackc;
    e.up  = up;
    e.err = e_err;
    e.cnt = cnt_m;
    q.push_back(e);
    while (cyc < ackc) begin
      s1_done = ((cyc - run0) == k1);
      s2_done = ((cyc - run0) == k2);
      tick();
    end
    s1_done = 1'b0;
    s2_done = 1'b0;
    chk("done_ep_rst", ep_rst, 1);
    tick();
    req_up = 1'b0;
    req_dn = 1'b0;
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (3) tick();
    chk("rst_ep_rst", ep_rst, 1);
    chk("rst_updown", updown, 0);
    chk("rst_ack_up", ack_up, 0);
    chk("rst_ack_dn", ack_dn, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", xfer_cnt, 0);
    rst = 1'b1;
    tick();

    // Basic UP transfer, done 10 cycles into RUN, req held past ack.
    xfer(1'b1, 9, 9, 1'b0);
    chk("cnt_after_1", xfer_cnt, 1);
    // Out-of-order done arrival, then same-cycle arrival with req dropped early.
    xfer(1'b0, 9, 4, 1'b0);
    xfer(1'b1, 5, 5, 1'b1);
    // No done at all: timeout (count unchanged).
    xfer(1'b0, -1, -1, 1'b1);
    chk("cnt_after_to", xfer_cnt, 3);
    // Fourth success wraps the 2-bit counter.
    xfer(1'b1, 0, 0, 1'b0);
    chk("cnt_wrap", xfer_cnt, 0);

    // Reset in the middle of RUN.
    req_up = 1'b1;
    repeat (5) tick();
    chk("mid_run_ep_rst", ep_rst, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ep_rst", ep_rst, 1);
    chk("mid_rst_updown", updown, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", xfer_cnt, 0);
    req_up = 1'b0;
    cnt_m  = 0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Both requests held: grants alternate UP, DN, UP, DN; counter 1,2,3,0.
    req_up = 1'b1;
    req_dn = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick();
      tick();
      tick();
      chk("rr_run_updown", updown, (g % 2 == 0) ? 1 : 0);
      chk("rr_run_ep_rst", ep_rst, 0);
      s1_done = 1'b1;
      s2_done = 1'b1;
      cnt_m = (cnt_m + 1) % 4;
      e.cyc = cyc + 1;
      e.up  = (g % 2 == 0);
      e.err = 1'b0;
      e.cnt = cnt_m;
      q.push_back(e);
      tick();
      s1_done = 1'b0;
      s2_done = 1'b0;
      chk("rr_done_updown", updown, (g % 2 == 0) ? 1 : 0);
      if (g == 3) begin
        req_up = 1'b0;
        req_dn = 1'b0;
      end
      tick();
    end
    chk("rr_cnt_wrap", xfer_cnt, 0);

    repeat (4) tick();
    chk("final_busy", busy, 0);
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
